// File: rtl/fifo_pkg.sv
// Shared sizing for the single-clock show-ahead FIFO.
package fifo_pkg;

  localparam int DATASIZE_DEF   = 8;
  localparam int ADDRSIZE_DEF   = 4;
  localparam int AEMPTY_LVL_DEF = 1;
  localparam int DEPTH_DEF      = 1 << ADDRSIZE_DEF;
  localparam int PTRW_DEF       = ADDRSIZE_DEF + 1;

endpackage : fifo_pkg

// File: rtl/fifo_if.sv
// Producer/consumer handshake bundle for the FIFO.
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF
);

  logic [DATASIZE-1:0] WDATA_I;
  logic                WINC_I;
  logic                WFULL_O;
  logic                RINC_I;
  logic [DATASIZE-1:0] RDATA_O;
  logic                REMPTY_O;
  logic                AREMPTY_O;

  // Side that drives requests and write data (producer + consumer).
  modport master (
    output WDATA_I, WINC_I, RINC_I,
    input  WFULL_O, RDATA_O, REMPTY_O, AREMPTY_O
  );

  // FIFO side.
  modport slave (
    input  WDATA_I, WINC_I, RINC_I,
    output WFULL_O, RDATA_O, REMPTY_O, AREMPTY_O
  );

endinterface : fifo_if

// File: rtl/fifo_mem.sv
// Storage array: synchronous write port, asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int ADDRSIZE = ADDRSIZE_DEF
) (
  input  logic                CLK_I,
  input  logic                wen_i,
  input  logic [ADDRSIZE-1:0] waddr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic [ADDRSIZE-1:0] raddr_i,
  output logic [DATASIZE-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem_q [DEPTH];

  // Write the addressed word; contents are intentionally not reset.
  always_ff @(posedge CLK_I) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem

// File: rtl/fifo_top.sv
// Single-clock FIFO: pointers, status flags, accept logic, head-word gating.
module fifo_top
  import fifo_pkg::*;
#(
  parameter int DATASIZE   = DATASIZE_DEF,
  parameter int ADDRSIZE   = ADDRSIZE_DEF,
  parameter int AEMPTY_LVL = AEMPTY_LVL_DEF
) (
  input  logic   CLK_I,
  input  logic   RST_I,
  fifo_if.slave  bus
);

  localparam int PTRW = ADDRSIZE + 1;

  logic [PTRW-1:0]     wptr_q, wptr_d;
  logic [PTRW-1:0]     rptr_q, rptr_d;
  logic [PTRW-1:0]     occ_s;
  logic                empty_s;
  logic                full_s;
  logic                wen_s;
  logic                ren_s;
  logic                mem_wen_s;
  logic [DATASIZE-1:0] mem_rdata_s;

  // Flags from registered pointers; acceptance and next pointers from them.
  always_comb begin
    occ_s   = wptr_q - rptr_q;
    empty_s = (wptr_q == rptr_q);
    full_s  = (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]) &&
              (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]);
    ren_s   = bus.RINC_I && !empty_s;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    wen_s   = bus.WINC_I && (!full_s || ren_s);
    if (wen_s) begin
      wptr_d = wptr_q + PTRW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (ren_s) begin
      rptr_d = rptr_q + PTRW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    // Reset wins over a concurrent write, so nothing lands in storage.
    if (RST_I) begin
      mem_wen_s = 1'b0;
    end else begin
      mem_wen_s = wen_s;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  fifo_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .CLK_I   (CLK_I),
    .wen_i   (mem_wen_s),
    .waddr_i (wptr_q[ADDRSIZE-1:0]),
    .wdata_i (bus.WDATA_I),
    .raddr_i (rptr_q[ADDRSIZE-1:0]),
    .rdata_o (mem_rdata_s)
  );

  assign bus.WFULL_O   = full_s;
  assign bus.REMPTY_O  = empty_s;
  assign bus.AREMPTY_O = (occ_s <= PTRW'(AEMPTY_LVL));
  assign bus.RDATA_O   = empty_s ? '0 : mem_rdata_s;

endmodule : fifo_top

// File: tb/tb_fifo_top.sv
// Directed bench for fifo_top: reset, ordering, full/empty boundaries, wrap.
module tb_fifo_top;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fifo_if #(.DATASIZE(8)) bus ();

  fifo_top dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    bus.WINC_I  = w;
    bus.RINC_I  = r;
    bus.WDATA_I = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b1, 1'b0, 8'd55);

    // Reset with a write pending: nothing stored.
    tick();
    chk1("rst_full",   bus.WFULL_O,   1'b0);
    chk1("rst_empty",  bus.REMPTY_O,  1'b1);
    chk1("rst_aempty", bus.AREMPTY_O, 1'b1);
    chk8("rst_rdata",  bus.RDATA_O,   8'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'd0);
    tick();
    chk1("rst_nostore", bus.REMPTY_O, 1'b1);

    // Five writes then five reads in order.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'(10 + i));
      tick();
      if (i == 0) begin
        chk1("w1_aempty", bus.AREMPTY_O, 1'b1);
        chk1("w1_empty",  bus.REMPTY_O,  1'b0);
        chk8("w1_head",   bus.RDATA_O,   8'd10);
      end else if (i == 1) begin
        chk1("w2_aempty", bus.AREMPTY_O, 1'b0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk8("seq_head", bus.RDATA_O, 8'(10 + i));
      drive(1'b0, 1'b1, 8'd0);
      tick();
    end
    drive(1'b0, 1'b0, 8'd0);
    chk1("seq_empty", bus.REMPTY_O, 1'b1);
    chk8("seq_rdata0", bus.RDATA_O, 8'd0);

    // Fill to 16, overflow attempt ignored, drain.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      tick();
      if (i == 14) chk1("fill15_full", bus.WFULL_O, 1'b0);
    end
    chk1("fill16_full", bus.WFULL_O, 1'b1);
    drive(1'b1, 1'b0, 8'd99);
    tick();
    chk1("ovf_full", bus.WFULL_O, 1'b1);
    chk8("ovf_head", bus.RDATA_O, 8'd0);
    for (int i = 0; i < 16; i++) begin
      chk8("drain_head", bus.RDATA_O, 8'(i));
      drive(1'b0, 1'b1, 8'd0);
      tick();
      if (i == 0) chk1("drain_notfull", bus.WFULL_O, 1'b0);
    end
    drive(1'b0, 1'b0, 8'd0);
    chk1("drain_empty", bus.REMPTY_O, 1'b1);

    // Full FIFO with simultaneous write and read.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      tick();
    end
    drive(1'b1, 1'b1, 8'd200);
    tick();
    drive(1'b0, 1'b0, 8'd0);
    chk1("fullrw_full", bus.WFULL_O, 1'b1);
    chk8("fullrw_head", bus.RDATA_O, 8'd1);
    for (int i = 0; i < 16; i++) begin
      chk8("fullrw_drain", bus.RDATA_O, (i == 15) ? 8'd200 : 8'(i + 1));
      drive(1'b0, 1'b1, 8'd0);
      tick();
    end
    drive(1'b0, 1'b0, 8'd0);
    chk1("fullrw_empty", bus.REMPTY_O, 1'b1);

    // Reads on empty are ignored; simultaneous write still lands.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'd0);
      tick();
      chk1("empty_rd", bus.REMPTY_O, 1'b1);
      chk8("empty_rd_data", bus.RDATA_O, 8'd0);
    end
    drive(1'b1, 1'b1, 8'd7);
    tick();
    drive(1'b0, 1'b0, 8'd0);
    chk1("emptyrw_empty",  bus.REMPTY_O,  1'b0);
    chk8("emptyrw_head",   bus.RDATA_O,   8'd7);
    chk1("emptyrw_aempty", bus.AREMPTY_O, 1'b1);
    drive(1'b0, 1'b1, 8'd0);
    tick();
    drive(1'b0, 1'b0, 8'd0);
    chk1("emptyrw_pop", bus.REMPTY_O, 1'b1);

    // Reset mid-stream discards data.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'(50 + i));
      tick();
    end
    chk8("mid_head", bus.RDATA_O, 8'd50);
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'd77);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'd0);
    chk1("mid_rst_empty", bus.REMPTY_O, 1'b1);
    chk1("mid_rst_full",  bus.WFULL_O,  1'b0);
    chk8("mid_rst_rdata", bus.RDATA_O,  8'd0);
    drive(1'b1, 1'b0, 8'd42);
    tick();
    drive(1'b0, 1'b0, 8'd0);
    chk8("post_rst_42", bus.RDATA_O, 8'd42);
    drive(1'b0, 1'b1, 8'd0);
    tick();
    drive(1'b0, 1'b0, 8'd0);
    chk1("post_rst_empty", bus.REMPTY_O, 1'b1);

    // 40 write/read pairs take both pointers through a full wrap.
    for (int j = 0; j < 40; j++) begin
      drive(1'b1, 1'b0, 8'(j + 3));
      tick();
      chk8("wrap_head", bus.RDATA_O, 8'(j + 3));
      chk1("wrap_full", bus.WFULL_O, 1'b0);
      drive(1'b0, 1'b1, 8'd0);
      tick();
      chk1("wrap_empty", bus.REMPTY_O, 1'b1);
    end
    drive(1'b0, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_top
